// File: rtl/gate_selftest_ctrl.sv
// Built-in self-test sequencer for a 2-input OR/AND/XOR/XNOR gate unit.
// Walks the four operand vectors and accumulates sticky per-vector and per-gate mismatch flags.

module gate_selftest_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_or,
    input  logic       gate_and,
    input  logic       gate_xor,
    input  logic       gate_xnor,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] vec_idx,
    output logic [3:0] err_mask,
    output logic [3:0] err_gate
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    // Reference gate results, bit order matches err_gate: {xnor, xor, and, or}.
    function automatic logic [3:0] gate_expect(input logic a, input logic b);
        return {~(a ^ b), a ^ b, a & b, a | b};
    endfunction

    state_t     state_r, state_nxt_s;
    logic [3:0] dwell_r, dwell_nxt_s;
    logic [1:0] vec_r, vec_nxt_s;
    logic [3:0] err_mask_r, err_mask_nxt_s;
    logic [3:0] err_gate_r, err_gate_nxt_s;
    logic       pass_r, pass_nxt_s;
    logic       done_r, done_nxt_s;
    logic       busy_r, busy_nxt_s;
    logic       gate_a_r, gate_a_nxt_s;
    logic       gate_b_r, gate_b_nxt_s;
    logic [3:0] mismatch_s;
    logic [3:0] mask_acc_s;
    logic       run_nxt_s;
    logic       in_run_s;
    logic       in_done_s;

    // Compare the gate unit against the reference for the vector currently held.
    always_comb begin
        mismatch_s = {gate_xnor, gate_xor, gate_and, gate_or} ^ gate_expect(vec_r[1], vec_r[0]);
        mask_acc_s = err_mask_r | ((|mismatch_s) ? (4'b0001 << vec_r) : 4'b0000);
    end

    // Next-state and next-output logic; abort leaves the sticky error bits untouched.
    always_comb begin
        state_nxt_s    = state_r;
        dwell_nxt_s    = dwell_r;
        vec_nxt_s      = vec_r;
        err_mask_nxt_s = err_mask_r;
        err_gate_nxt_s = err_gate_r;
        pass_nxt_s     = pass_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    state_nxt_s    = ST_APPLY;
                    dwell_nxt_s    = 4'd0;
                    vec_nxt_s      = 2'd0;
                    err_mask_nxt_s = 4'b0000;
                    err_gate_nxt_s = 4'b0000;
                    pass_nxt_s     = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                    dwell_nxt_s = 4'd0;
                    vec_nxt_s   = 2'd0;
                    pass_nxt_s  = 1'b0;
                end else if (dwell_r == DWELL_LAST) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    dwell_nxt_s = dwell_r + 4'd1;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                    dwell_nxt_s = 4'd0;
                    vec_nxt_s   = 2'd0;
                    pass_nxt_s  = 1'b0;
                end else begin
                    err_mask_nxt_s = mask_acc_s;
                    err_gate_nxt_s = err_gate_r | mismatch_s;
                    if (vec_r == 2'd3) begin
                        state_nxt_s = ST_DONE;
                        pass_nxt_s  = (mask_acc_s == 4'b0000);
                    end else begin
                        state_nxt_s = ST_APPLY;
                        vec_nxt_s   = vec_r + 2'd1;
                        dwell_nxt_s = 4'd0;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                dwell_nxt_s = 4'd0;
                vec_nxt_s   = 2'd0;
                pass_nxt_s  = 1'b0;
            end
        endcase

        // Status and operands are registered from the next state so they line up with it.
        run_nxt_s    = (state_nxt_s == ST_APPLY) || (state_nxt_s == ST_CHECK);
        busy_nxt_s   = run_nxt_s;
        done_nxt_s   = (state_nxt_s == ST_DONE);
        gate_a_nxt_s = run_nxt_s ? vec_nxt_s[1] : 1'b0;
        gate_b_nxt_s = run_nxt_s ? vec_nxt_s[0] : 1'b0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            dwell_r    <= 4'd0;
            vec_r      <= 2'd0;
            err_mask_r <= 4'b0000;
            err_gate_r <= 4'b0000;
            pass_r     <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            gate_a_r   <= 1'b0;
            gate_b_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            dwell_r    <= dwell_nxt_s;
            vec_r      <= vec_nxt_s;
            err_mask_r <= err_mask_nxt_s;
            err_gate_r <= err_gate_nxt_s;
            pass_r     <= pass_nxt_s;
            done_r     <= done_nxt_s;
            busy_r     <= busy_nxt_s;
            gate_a_r   <= gate_a_nxt_s;
            gate_b_r   <= gate_b_nxt_s;
        end
    end

    assign gate_a   = gate_a_r;
    assign gate_b   = gate_b_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign vec_idx  = vec_r;
    assign err_mask = err_mask_r;
    assign err_gate = err_gate_r;

    assign in_run_s  = (state_r == ST_APPLY) || (state_r == ST_CHECK);
    assign in_done_s = (state_r == ST_DONE);

    gate_selftest_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_run  (in_run_s),
        .in_done (in_done_s),
        .busy    (busy_r),
        .done    (done_r),
        .pass    (pass_r)
    );

endmodule

// Status-consistency properties for gate_selftest_ctrl.
module gate_selftest_chk (
    input logic clk,
    input logic rst_n,
    input logic in_run,
    input logic in_done,
    input logic busy,
    input logic done,
    input logic pass
);

    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n) busy == in_run);
    a_done_state: assert property (@(posedge clk) disable iff (!rst_n) done == in_done);
    a_busy_done:  assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
    a_pass_done:  assert property (@(posedge clk) disable iff (!rst_n) pass |-> done);

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Scoreboard bench for gate_selftest_ctrl: stimulus queues expected snapshots,
// a negedge monitor compares them whenever busy falls or a snapshot is requested.

module tb_gate_selftest_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start0, start1, abort;
    logic [3:0] fault_en, fault_val;
    logic [1:0] snap_req;

    logic [1:0] busy_w, done_w, pass_w, ga_w, gb_w;
    logic [1:0] vec_w  [2];
    logic [3:0] mask_w [2];
    logic [3:0] gerr_w [2];

    logic g0_or, g0_and, g0_xor, g0_xnor;
    logic g1_or, g1_and, g1_xor, g1_xnor;

    typedef struct {
        int         inst;
        int         tag;
        int         len;
        logic       busy;
        logic       done;
        logic       pass;
        logic [1:0] vec;
        logic [3:0] mask;
        logic [3:0] gerr;
        logic       chk_ops;
        logic       ga;
        logic       gb;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   run_len [2];
    bit   prev_busy [2];

    // Gate unit model for the DWELL=4 instance, with per-gate stuck-at injection.
    assign g0_or   = fault_en[0] ? fault_val[0] : (ga_w[0] | gb_w[0]);
    assign g0_and  = fault_en[1] ? fault_val[1] : (ga_w[0] & gb_w[0]);
    assign g0_xor  = fault_en[2] ? fault_val[2] : (ga_w[0] ^ gb_w[0]);
    assign g0_xnor = fault_en[3] ? fault_val[3] : ~(ga_w[0] ^ gb_w[0]);
    assign g1_or   = ga_w[1] | gb_w[1];
    assign g1_and  = ga_w[1] & gb_w[1];
    assign g1_xor  = ga_w[1] ^ gb_w[1];
    assign g1_xnor = ~(ga_w[1] ^ gb_w[1]);

    gate_selftest_ctrl #(.DWELL(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
        .gate_a(ga_w[0]), .gate_b(gb_w[0]),
        .gate_or(g0_or), .gate_and(g0_and), .gate_xor(g0_xor), .gate_xnor(g0_xnor),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .vec_idx(vec_w[0]), .err_mask(mask_w[0]), .err_gate(gerr_w[0])
    );

    gate_selftest_ctrl #(.DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .gate_a(ga_w[1]), .gate_b(gb_w[1]),
        .gate_or(g1_or), .gate_and(g1_and), .gate_xor(g1_xor), .gate_xnor(g1_xnor),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .vec_idx(vec_w[1]), .err_mask(mask_w[1]), .err_gate(gerr_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary by 100000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input int tag, input string what, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL ev%0d %s: got %0d expected %0d", tag, what, act, exp);
    endtask

    task automatic compare_event(input int i);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event inst%0d: got output event (busy=%0d done=%0d), expected none",
                     i, busy_w[i], done_w[i]);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, "inst",     i,                 e.inst);
            chk(e.tag, "busy_len", run_len[i],        e.len);
            chk(e.tag, "busy",     int'(busy_w[i]),   int'(e.busy));
            chk(e.tag, "done",     int'(done_w[i]),   int'(e.done));
            chk(e.tag, "pass",     int'(pass_w[i]),   int'(e.pass));
            chk(e.tag, "vec_idx",  int'(vec_w[i]),    int'(e.vec));
            chk(e.tag, "err_mask", int'(mask_w[i]),   int'(e.mask));
            chk(e.tag, "err_gate", int'(gerr_w[i]),   int'(e.gerr));
            if (e.chk_ops) begin
                chk(e.tag, "gate_a", int'(ga_w[i]), int'(e.ga));
                chk(e.tag, "gate_b", int'(gb_w[i]), int'(e.gb));
            end
        end
    endtask

    // Monitor: counts busy cycles and checks on busy falling or a snapshot request.
    initial begin
        run_len[0] = 0; run_len[1] = 0;
        prev_busy[0] = 1'b0; prev_busy[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (busy_w[i] === 1'b1) run_len[i]++;
                if ((prev_busy[i] && busy_w[i] === 1'b0) || snap_req[i]) compare_event(i);
                if (busy_w[i] !== 1'b1) run_len[i] = 0;
                prev_busy[i] = (busy_w[i] === 1'b1);
            end
        end
    end

    task automatic push_exp(input int inst, input int tag, input int len,
                            input logic bsy, input logic dn, input logic ps,
                            input logic [1:0] v, input logic [3:0] m, input logic [3:0] g,
                            input logic ops, input logic a_e, input logic b_e);
        exp_t e;
        e.inst = inst; e.tag = tag; e.len = len;
        e.busy = bsy; e.done = dn; e.pass = ps;
        e.vec = v; e.mask = m; e.gerr = g;
        e.chk_ops = ops; e.ga = a_e; e.gb = b_e;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        if (i == 0) start0 = 1'b1;
        else start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic snap(input logic [1:0] which);
        snap_req = which;
        tick();
        snap_req = 2'b00;
    endtask

    task automatic wait_idle(input int i, input int tag);
        int n;
        n = 0;
        while (busy_w[i] === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (busy_w[i] === 1'b1) begin
            n_total++;
            $display("FAIL timeout ev%0d: busy still 1 after %0d cycles, expected 0", tag, n);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
        fault_en = 4'b0000; fault_val = 4'b0000; snap_req = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state of both instances.
        push_exp(0, 1, 0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        push_exp(1, 2, 0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        snap(2'b11);

        // Fault-free run: 20 busy cycles, done/pass on the 21st.
        push_exp(0, 3, 20, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        pulse_start(0);
        wait_idle(0, 3);

        // xor stuck at 0: vectors 1 and 2 fail.
        fault_en = 4'b0100; fault_val = 4'b0000;
        push_exp(0, 4, 20, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0110, 4'b0100, 1'b0, 1'b0, 1'b0);
        pulse_start(0);
        wait_idle(0, 4);

        // xnor stuck 1, and stuck 0; restarting from DONE clears earlier errors.
        fault_en = 4'b1010; fault_val = 4'b1000;
        push_exp(0, 5, 20, 1'b0, 1'b1, 1'b0, 2'd3, 4'b1110, 4'b1010, 1'b0, 1'b0, 1'b0);
        pulse_start(0);
        wait_idle(0, 5);

        // Abort during vector 2 APPLY (busy cycle 12).
        fault_en = 4'b0000;
        push_exp(0, 6, 12, 1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        push_exp(0, 7, 12, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        pulse_start(0);
        repeat (11) tick();
        abort = 1'b1;
        snap_req = 2'b01;
        tick();
        abort = 1'b0;
        snap_req = 2'b00;
        tick();

        // start together with abort in IDLE must not launch a run.
        push_exp(0, 8, 0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        start0 = 1'b1; abort = 1'b1;
        tick();
        start0 = 1'b0; abort = 1'b0;
        snap(2'b01);

        // New run after abort completes normally.
        push_exp(0, 9, 20, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        pulse_start(0);
        wait_idle(0, 9);

        // abort, then start+abort, in DONE: results held.
        push_exp(0, 10, 0, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0; abort = 1'b0;
        snap(2'b01);

        // start re-pulsed at vector 1 is ignored; latency unchanged.
        push_exp(0, 11, 20, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        pulse_start(0);
        repeat (5) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_idle(0, 11);

        // Reset in vector 3 CHECK, with xor fault to make errors visible first.
        fault_en = 4'b0100; fault_val = 4'b0000;
        push_exp(0, 12, 20, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0110, 4'b0100, 1'b1, 1'b1, 1'b1);
        push_exp(0, 13, 20, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        pulse_start(0);
        repeat (19) tick();
        rst_n = 1'b0;
        snap_req = 2'b01;
        tick();
        rst_n = 1'b1;
        snap_req = 2'b00;
        fault_en = 4'b0000;
        repeat (30) tick();
        push_exp(0, 14, 0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        snap(2'b01);

        // DWELL=1 instance: 8 busy cycles, done on cycle 9.
        push_exp(1, 15, 8, 1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        pulse_start(1);
        wait_idle(1, 15);

        repeat (3) tick();
        chk(0, "queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gate_selftest_ctrl.md
GATE_SELFTEST_CTRL -- requirements
Module: gate_selftest_ctrl

Interface
REQ-001 Parameter: DWELL, default 4, hold cycles per operand vector before sampling; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all logic rising-edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-004 Port: start  input  1  begin self-test; single-cycle pulse or level.
REQ-005 Port: abort  input  1  cancel run in progress.
REQ-006 Port: gate_a  output  1  operand a to gate unit.
REQ-007 Port: gate_b  output  1  operand b to gate unit.
REQ-008 Port: gate_or, gate_and, gate_xor, gate_xnor  input  1 each  gate unit results.
REQ-009 Port: busy  output  1  run in progress.
REQ-010 Port: done  output  1  run completed, results valid.
REQ-011 Port: pass  output  1  done with zero mismatches.
REQ-012 Port: vec_idx  output  2  current vector index.
REQ-013 Port: err_mask  output  4  bit i set: any mismatch on vector i.
REQ-014 Port: err_gate  output  4  mismatch per gate: [0] or, [1] and, [2] xor, [3] xnor.

Function
REQ-015 The FSM SHALL have states IDLE, APPLY, CHECK, DONE.
REQ-016 Operands SHALL be gate_a = vec_idx[1], gate_b = vec_idx[0], giving order (0,0),(0,1),(1,0),(1,1).
REQ-017 IDLE or DONE with start=1 and abort=0 SHALL go to APPLY next cycle with vec_idx=0, dwell counter=0, err_mask=0, err_gate=0, done=0, pass=0.
REQ-018 APPLY SHALL hold operands for exactly DWELL cycles, then go to CHECK.
REQ-019 CHECK SHALL last one cycle, operands still held, comparing each input against a|b, a&b, a^b, ~(a^b) of current operands.
REQ-020 A CHECK mismatch SHALL set err_mask[vec_idx] and the corresponding err_gate bits; bits SHALL only accumulate (sticky) within a run.
REQ-021 From CHECK: vec_idx<3 -> vec_idx+1, APPLY, dwell counter=0; vec_idx=3 -> DONE.
REQ-022 DONE SHALL assert done=1, pass=(err_mask==0 including the final CHECK result), busy=0, hold vec_idx=3 and all error bits until start or reset.
REQ-023 busy SHALL be 1 exactly in APPLY and CHECK.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort=1 in APPLY or CHECK SHALL go to IDLE next cycle: busy=0, done=0, pass=0, vec_idx=0, operands 0; err_mask/err_gate hold current values.
REQ-026 abort in IDLE or DONE SHALL have no effect; abort wins over start in the same cycle.
REQ-027 start-edge to done-rise latency SHALL be 4*(DWELL+1)+1 cycles (21 for DWELL=4).
REQ-028 gate inputs SHALL be sampled only in CHECK; values in other states SHALL not affect any output.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, gate_a=0, gate_b=0, busy=0, done=0, pass=0, vec_idx=0, err_mask=0, err_gate=0, dwell counter=0, regardless of state.
REQ-030 Reset mid-run SHALL discard the run; no done pulse SHALL follow until a new start.

Verification
REQ-031 DWELL=4, correct gate model, start pulse -> busy 20 cycles, done=1 and pass=1 on cycle 21, err_mask=0000, err_gate=0000.
REQ-032 gate_xor stuck at 0 -> done at cycle 21, pass=0, err_mask=0110, err_gate=0100.
REQ-033 gate_xnor stuck at 1 and gate_and stuck at 0 -> err_mask=1110, err_gate=1010, pass=0.
REQ-034 abort asserted during vector 2 APPLY -> IDLE next cycle, busy=0, done=0, vec_idx=0, operands 0; new start then completes normally with pass=1.
REQ-035 start re-pulsed while busy at vector 1 -> ignored, done still at cycle 21; start in DONE -> errors cleared, new run.
REQ-036 rst_n=0 for one cycle during vector 3 CHECK -> all outputs at reset values next cycle, no done until next start; DWELL=1 run -> done at cycle 9.
